// File: rtl/input_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// io_cond_pkg
// Shared definitions for the board input-conditioning path (switches and keys).
//
// Contents
//   CLK_HZ          system clock frequency of the clk domain (50 MHz)
//   ms_to_cycles()  converts a duration in milliseconds to clk cycles
//   DEBOUNCE_20MS   default debounce window, 20 ms expressed in clk cycles
//   db_phase_t      per-channel debounce phase: the synchronised level either
//                   matches the committed state (STABLE) or differs from it and
//                   is being timed (PENDING)
// -----------------------------------------------------------------------------
package io_cond_pkg;

    localparam int CLK_HZ = 50_000_000;

    // Cycles per millisecond is exact for any clock that is a multiple of
    // 1 kHz, so divide first to keep the product inside 32 bits.
    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    localparam int DEBOUNCE_20MS = ms_to_cycles(20);

    typedef enum logic {
        PH_STABLE  = 1'b0,
        PH_PENDING = 1'b1
    } db_phase_t;

endpackage : io_cond_pkg

// File: rtl/input_debouncer_if.sv
// -----------------------------------------------------------------------------
// input_debouncer_if
// Bundles the pin-side input vector and the conditioned outputs of the
// debouncer.
//
// Signals (all WIDTH wide except any_change_o)
//   raw_i         asynchronous pin levels, driven by the board / stimulus side
//   state_o       debounced level, active-high after polarity correction
//   rise_o        one-cycle pulse when a bit commits 0->1
//   fall_o        one-cycle pulse when a bit commits 1->0
//   any_change_o  OR of all rise/fall pulses
//
// Modports
//   master  drives raw_i, observes the conditioned outputs (pins / user side)
//   slave   the debouncer itself
// -----------------------------------------------------------------------------
interface input_debouncer_if #(
    parameter int WIDTH = 10
);

    logic [WIDTH-1:0] raw_i;
    logic [WIDTH-1:0] state_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic             any_change_o;

    modport master (
        output raw_i,
        input  state_o,
        input  rise_o,
        input  fall_o,
        input  any_change_o
    );

    modport slave (
        input  raw_i,
        output state_o,
        output rise_o,
        output fall_o,
        output any_change_o
    );

endinterface : input_debouncer_if

// File: rtl/input_debouncer_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// One debounce channel: synchroniser chain, stability counter, committed
// state and registered rise/fall event pulses.
//
// Parameters
//   SYNC_STAGES      synchroniser depth (>= 2)
//   DEBOUNCE_CYCLES  consecutive differing cycles needed to commit (>= 1)
//   ACTIVE_LOW       1: a raw 0 means asserted; 0: a raw 1 means asserted
//
// Ports
//   clk    system clock
//   rst    asynchronous active-high reset
//   raw    asynchronous pin level
//   state  debounced, polarity-corrected level
//   rise   one-cycle pulse on the edge that commits state 0->1
//   fall   one-cycle pulse on the edge that commits state 1->0
// -----------------------------------------------------------------------------
module debounce_bit
    import io_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic state,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic             POL      = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   state_reg;
    logic                   rise_reg;
    logic                   fall_reg;
    logic                   s;
    db_phase_t              phase;

    // Synchroniser resets to the inactive raw level so that a released reset
    // never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= {SYNC_STAGES{POL}};
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
        end
    end

    // Polarity-corrected synchronised level.
    assign s = sync_reg[SYNC_STAGES-1] ^ POL;

    always_comb begin
        phase = (s == state_reg) ? PH_STABLE : PH_PENDING;
    end

    // The counter holds how many consecutive edges have already seen s differ
    // from the committed state; the edge on which it would reach
    // DEBOUNCE_CYCLES commits instead, so it never exceeds DEBOUNCE_CYCLES-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            state_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            case (phase)
                PH_STABLE: begin
                    // Also covers a bounce back to the committed level.
                    cnt_reg <= '0;
                end
                PH_PENDING: begin
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= s;
                        cnt_reg   <= '0;
                        rise_reg  <= s;
                        fall_reg  <= ~s;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign state = state_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule : debounce_bit

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
// Input-side conditioner for board switches and keys. Every bit of raw_i is
// synchronised and debounced independently; the block presents a clean
// active-high level per bit plus one-cycle rise/fall event pulses.
//
// Parameters
//   WIDTH            number of independent input bits (must match dbus WIDTH)
//   SYNC_STAGES      synchroniser flops per bit (>= 2)
//   DEBOUNCE_CYCLES  stable cycles required to commit a change (>= 1)
//   ACTIVE_LOW       1: raw 0 means asserted (keys); 0: raw 1 asserted (switches)
//
// Ports
//   clk   system clock
//   rst   asynchronous active-high reset
//   dbus  input_debouncer_if.slave: raw_i in; state_o, rise_o, fall_o,
//         any_change_o out
// -----------------------------------------------------------------------------
module input_debouncer
    import io_cond_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic                clk,
    input  logic                rst,
    input_debouncer_if.slave    dbus
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("input_debouncer: SYNC_STAGES must be at least 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
            $error("input_debouncer: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] state_vec;
    logic [WIDTH-1:0] rise_vec;
    logic [WIDTH-1:0] fall_vec;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            debounce_bit #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .ACTIVE_LOW      (ACTIVE_LOW)
            ) u_bit (
                .clk   (clk),
                .rst   (rst),
                .raw   (dbus.raw_i[gi]),
                .state (state_vec[gi]),
                .rise  (rise_vec[gi]),
                .fall  (fall_vec[gi])
            );
        end
    endgenerate

    assign dbus.state_o      = state_vec;
    assign dbus.rise_o       = rise_vec;
    assign dbus.fall_o       = fall_vec;
    // Combinational, but only from registered pulses, so it is glitch-free
    // with respect to the raw pins.
    assign dbus.any_change_o = |(rise_vec | fall_vec);

endmodule : input_debouncer

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

    localparam int W = 4;
    localparam int S = 2;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    input_debouncer_if #(.WIDTH(W)) bus_h ();
    input_debouncer_if #(.WIDTH(W)) bus_l ();

    input_debouncer #(
        .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(0)
    ) dut_h (
        .clk  (clk),
        .rst  (rst),
        .dbus (bus_h)
    );

    input_debouncer #(
        .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1)
    ) dut_l (
        .clk  (clk),
        .rst  (rst),
        .dbus (bus_l)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A bit commits when the last D synchronised samples all disagree with the
    // committed level; a synchronised sample is the (polarity-corrected) pin
    // value from S edges earlier.
    logic [S-1:0]   m_pipe  [2][W];
    logic [D-1:0]   m_win   [2][W];
    logic [W-1:0]   m_state [2];
    logic [W-1:0]   m_rise  [2];
    logic [W-1:0]   m_fall  [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = '0;
            m_rise[i]  = '0;
            m_fall[i]  = '0;
            for (int b = 0; b < W; b++) begin
                m_pipe[i][b] = '0;
                m_win[i][b]  = '0;
            end
        end
    endtask

    task automatic model_step(input int inst, input logic [W-1:0] rawc);
        logic sv;
        for (int b = 0; b < W; b++) begin
            sv = m_pipe[inst][b][S-1];
            m_pipe[inst][b] = {m_pipe[inst][b][S-2:0], rawc[b]};
            m_win[inst][b]  = {m_win[inst][b][D-2:0], sv};
            m_rise[inst][b] = 1'b0;
            m_fall[inst][b] = 1'b0;
            if (m_win[inst][b] == {D{~m_state[inst][b]}}) begin
                m_state[inst][b] = sv;
                m_rise[inst][b]  = sv;
                m_fall[inst][b]  = ~sv;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                model_step(0, bus_h.raw_i);
                model_step(1, ~bus_l.raw_i);
            end
        end
    end

    // ---------------- every-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("model_state_h", bus_h.state_o, m_state[0]);
            chk("model_rise_h",  bus_h.rise_o,  m_rise[0]);
            chk("model_fall_h",  bus_h.fall_o,  m_fall[0]);
            chk("model_any_h",   bus_h.any_change_o, |(m_rise[0] | m_fall[0]));
            chk("model_state_l", bus_l.state_o, m_state[1]);
            chk("model_rise_l",  bus_l.rise_o,  m_rise[1]);
            chk("model_fall_l",  bus_l.fall_o,  m_fall[1]);
            chk("model_any_l",   bus_l.any_change_o, |(m_rise[1] | m_fall[1]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int pulses;
        logic p [7];
        p = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        bus_h.raw_i = '0;
        bus_l.raw_i = 4'hF;

        // 1. reset state, then idle
        tick(1);
        chk("rst_state_h", bus_h.state_o, 4'h0);
        chk("rst_rise_h",  bus_h.rise_o,  4'h0);
        chk("rst_fall_h",  bus_h.fall_o,  4'h0);
        chk("rst_any_h",   bus_h.any_change_o, 1'b0);
        chk("rst_state_l", bus_l.state_o, 4'h0);
        tick(1);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (bus_h.any_change_o || bus_l.any_change_o) pulses++;
        end
        chk("idle_pulses", pulses, 0);

        // 2. clean rise on bit 0, commit on edge 10
        bus_h.raw_i[0] = 1'b1;
        tick(9);
        chk("t2_state_e9", bus_h.state_o, 4'b0000);
        tick(1);
        chk("t2_state_e10", bus_h.state_o, 4'b0001);
        chk("t2_rise_e10",  bus_h.rise_o,  4'b0001);
        chk("t2_fall_e10",  bus_h.fall_o,  4'b0000);
        tick(1);
        chk("t2_rise_e11",  bus_h.rise_o,  4'b0000);

        // 3. 7-cycle glitch rejected; 8-cycle pulse accepted
        bus_h.raw_i[1] = 1'b1;
        tick(7);
        bus_h.raw_i[1] = 1'b0;
        tick(20);
        chk("t3_short_state", bus_h.state_o, 4'b0001);
        bus_h.raw_i[1] = 1'b1;
        tick(8);
        bus_h.raw_i[1] = 1'b0;
        tick(2);
        chk("t3_rise",       bus_h.rise_o,  4'b0010);
        chk("t3_state_hi",   bus_h.state_o, 4'b0011);
        tick(7);
        chk("t3_fall_early", bus_h.fall_o,  4'b0000);
        tick(1);
        chk("t3_fall",       bus_h.fall_o,  4'b0010);
        chk("t3_state_lo",   bus_h.state_o, 4'b0001);

        // 4. bounce on bit 2
        for (int i = 0; i < 7; i++) begin
            bus_h.raw_i[2] = p[i];
            tick(1);
        end
        bus_h.raw_i[2] = 1'b1;
        tick(9);
        chk("t4_state_e9", bus_h.state_o, 4'b0001);
        tick(1);
        chk("t4_rise",     bus_h.rise_o,  4'b0100);
        chk("t4_state",    bus_h.state_o, 4'b0101);
        bus_h.raw_i[2] = 1'b0;
        tick(12);
        chk("t4_release",  bus_h.state_o, 4'b0001);

        // 5. simultaneous commits
        bus_h.raw_i[3:2] = 2'b11;
        tick(10);
        chk("t5_rise",     bus_h.rise_o, 4'b1100);
        chk("t5_any",      bus_h.any_change_o, 1'b1);
        chk("t5_state",    bus_h.state_o, 4'b1101);
        tick(1);
        chk("t5_any_off",  bus_h.any_change_o, 1'b0);
        chk("t5_rise_off", bus_h.rise_o, 4'b0000);

        // 6. active-low instance and reset mid-count
        chk("t6_idle_l", bus_l.state_o, 4'b0000);
        bus_l.raw_i[0] = 1'b0;
        tick(9);
        chk("t6_state_e9_l", bus_l.state_o, 4'b0000);
        tick(1);
        chk("t6_state_l", bus_l.state_o, 4'b0001);
        chk("t6_rise_l",  bus_l.rise_o,  4'b0001);
        bus_l.raw_i[0] = 1'b1;
        tick(12);
        chk("t6_release_l", bus_l.state_o, 4'b0000);
        bus_l.raw_i[0] = 1'b0;
        tick(7);
        rst = 1'b1;
        #1;
        chk("t6_rst_state_h", bus_h.state_o, 4'b0000);
        chk("t6_rst_state_l", bus_l.state_o, 4'b0000);
        chk("t6_rst_any_l",   bus_l.any_change_o, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(9);
        chk("t6_post_e9_l", bus_l.state_o, 4'b0000);
        chk("t6_post_e9_h", bus_h.state_o, 4'b0000);
        tick(1);
        chk("t6_post_rise_l",  bus_l.rise_o,  4'b0001);
        chk("t6_post_rise_h",  bus_h.rise_o,  4'b1101);
        chk("t6_post_state_h", bus_h.state_o, 4'b1101);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_input_debouncer
